// File: rtl/ps2_key_event_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_key_event_sequencer
//
// Turns the raw scancode byte stream of a PS/2 keyboard receiver into clean
// per-key events for four tracked keys: space, enter, one and two.
//
// The byte stream is decoded by a small prefix FSM:
//   IDLE    - waiting for a key code or a prefix byte
//   EXT     - E0 seen; the next key code is an extended one
//   BRK     - F0 seen; the next key code is a release (break)
//   EXT_BRK - E0 F0 seen; the next key code is an extended release
// A prefix state that waits too long for its next byte gives up, returns to
// IDLE and reports a protocol error.
//
// A first-press latch records which tracked key went down first after the
// most recent arm pulse.
//
// Ports
//   CLOCK_50          in   1  system clock, all logic on the rising edge
//   reset             in   1  synchronous, active-high reset
//   received_data     in   8  scancode byte from the PS/2 receiver
//   received_data_en  in   1  strobe: received_data is valid this cycle
//   arm               in   1  pulse: clear and re-enable the first-press latch
//   key_held          out  4  level per key: [0] space [1] enter [2] one [3] two
//   key_press         out  4  one-cycle pulse on a released-to-held transition
//   key_release       out  4  one-cycle pulse on a held-to-released transition
//   first_key         out  2  index of the first key pressed since arm
//   first_valid       out  1  first_key holds a captured value
//   proto_error       out  1  pulse on prefix timeout or error byte (00/FF)
//
// Parameters
//   TIMEOUT_CYCLES    cycles a prefix state may wait for its next byte
// -----------------------------------------------------------------------------
module ps2_key_event_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       arm,
    output logic [3:0] key_held,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [1:0] first_key,
    output logic       first_valid,
    output logic       proto_error
);

    // Counter just wide enough to reach TIMEOUT_CYCLES-1.
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Scancode bytes with special meaning.
    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] BYTE_BRK   = 8'hF0;
    localparam logic [7:0] BYTE_ERR_0 = 8'h00;
    localparam logic [7:0] BYTE_ERR_1 = 8'hFF;

    // Set-2 make codes of the tracked keys.
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_ONE   = 8'h16;
    localparam logic [7:0] CODE_TWO   = 8'h1E;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] timeout_cnt, timeout_cnt_next;
    logic [3:0]       key_held_next;
    logic [3:0]       key_press_next;
    logic [3:0]       key_release_next;
    logic [1:0]       first_key_next;
    logic             first_valid_next;
    logic             proto_error_next;

    // Decode scratch signals for the byte being accepted this cycle.
    logic             is_extended;
    logic             is_break;
    logic             key_hit;
    logic [1:0]       key_idx;

    // Lowest set bit of a key vector; at most one bit is ever set because a
    // single byte can only address a single key.
    function automatic logic [1:0] lowest_index(input logic [3:0] keys);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (keys[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            timeout_cnt <= '0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            first_key   <= '0;
            first_valid <= 1'b0;
            proto_error <= 1'b0;
        end else begin
            state       <= state_next;
            timeout_cnt <= timeout_cnt_next;
            key_held    <= key_held_next;
            key_press   <= key_press_next;
            key_release <= key_release_next;
            first_key   <= first_key_next;
            first_valid <= first_valid_next;
            proto_error <= proto_error_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next       = state;
        timeout_cnt_next = timeout_cnt;
        key_held_next    = key_held;
        key_press_next   = '0;
        key_release_next = '0;
        first_key_next   = first_key;
        first_valid_next = first_valid;
        proto_error_next = 1'b0;
        is_extended      = (state == EXT) || (state == EXT_BRK);
        is_break         = (state == BRK) || (state == EXT_BRK);
        key_hit          = 1'b0;
        key_idx          = 2'd0;

        if (received_data_en) begin
            // Any accepted byte restarts the prefix timeout.
            timeout_cnt_next = '0;

            case (received_data)
                BYTE_EXT: begin
                    // E0 always (re)starts an extended sequence, even in the
                    // middle of a break sequence.
                    state_next = EXT;
                end

                BYTE_BRK: begin
                    // F0 after a break prefix is redundant and leaves the
                    // state as it is.
                    case (state)
                        IDLE:    state_next = BRK;
                        EXT:     state_next = EXT_BRK;
                        default: state_next = state;
                    endcase
                end

                BYTE_ERR_0, BYTE_ERR_1: begin
                    state_next       = IDLE;
                    proto_error_next = 1'b1;
                end

                default: begin
                    // Any other byte completes a sequence as a key code.
                    state_next = IDLE;

                    if (is_extended) begin
                        // Only keypad enter is tracked among extended keys;
                        // it shares the enter slot with the main enter key.
                        if (received_data == CODE_ENTER) begin
                            key_hit = 1'b1;
                            key_idx = 2'd1;
                        end
                    end else begin
                        case (received_data)
                            CODE_SPACE: begin key_hit = 1'b1; key_idx = 2'd0; end
                            CODE_ENTER: begin key_hit = 1'b1; key_idx = 2'd1; end
                            CODE_ONE:   begin key_hit = 1'b1; key_idx = 2'd2; end
                            CODE_TWO:   begin key_hit = 1'b1; key_idx = 2'd3; end
                            default:    key_hit = 1'b0;
                        endcase
                    end

                    // Only real transitions produce pulses: typematic repeats
                    // of a held key and breaks of a released key are dropped.
                    if (key_hit) begin
                        if (!is_break && !key_held[key_idx]) begin
                            key_held_next[key_idx]  = 1'b1;
                            key_press_next[key_idx] = 1'b1;
                        end else if (is_break && key_held[key_idx]) begin
                            key_held_next[key_idx]    = 1'b0;
                            key_release_next[key_idx] = 1'b1;
                        end
                    end
                end
            endcase
        end else if (state != IDLE) begin
            // A prefix is waiting for its next byte; give up after the budget.
            if (timeout_cnt == CNT_LAST) begin
                state_next       = IDLE;
                timeout_cnt_next = '0;
                proto_error_next = 1'b1;
            end else begin
                timeout_cnt_next = timeout_cnt + 1'b1;
            end
        end else begin
            timeout_cnt_next = '0;
        end

        // First-press latch, driven from the registered press pulse. A press
        // pulse coinciding with arm wins over the clear, so the new key is
        // captured immediately instead of being lost.
        if ((key_press != '0) && (!first_valid || arm)) begin
            first_valid_next = 1'b1;
            first_key_next   = lowest_index(key_press);
        end else if (arm) begin
            first_valid_next = 1'b0;
            first_key_next   = 2'd0;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for ps2_key_event_sequencer.
// A directed vector table with hand-derived expectations, a few multi-cycle
// timeout sequences, then randomized byte traffic. Every cycle the outputs are
// also compared against a behavioural model built from prefix flags and a
// key-code lookup table.
// -----------------------------------------------------------------------------
module tb_ps2_key_event_sequencer;

    localparam int T = 20;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       arm;
    logic [3:0] key_held;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [1:0] first_key;
    logic       first_valid;
    logic       proto_error;

    ps2_key_event_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .arm              (arm),
        .key_held         (key_held),
        .key_press        (key_press),
        .key_release      (key_release),
        .first_key        (first_key),
        .first_valid      (first_valid),
        .proto_error      (proto_error)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // All outputs packed: {held, press, release, first_key, first_valid, err}
    logic [15:0] dut_vec;
    assign dut_vec = {key_held, key_press, key_release, first_key, first_valid, proto_error};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pk(input logic [3:0] h, input logic [3:0] p,
                                       input logic [3:0] rl, input logic [1:0] fk,
                                       input bit fv, input bit er);
        return {h, p, rl, fk, fv, er};
    endfunction

    // ---------------------------------------------------------------- model
    logic [7:0] codes [4] = '{8'h29, 8'h5A, 8'h16, 8'h1E};
    bit         m_held [4];
    bit         m_ext, m_brk;
    int         m_idle;
    logic [3:0] m_press, m_rel;
    logic [1:0] m_fk;
    bit         m_fv, m_err;

    function automatic logic [15:0] model_vec();
        return {m_held[3], m_held[2], m_held[1], m_held[0], m_press, m_rel, m_fk, m_fv, m_err};
    endfunction

    task automatic model_step(input logic [7:0] d, input bit e, input bit a, input bit r);
        int         key;
        logic [3:0] np, nr;
        bit         ne;
        if (r) begin
            foreach (m_held[i]) m_held[i] = 0;
            m_ext = 0; m_brk = 0; m_idle = 0;
            m_press = 0; m_rel = 0; m_fk = 0; m_fv = 0; m_err = 0;
            return;
        end
        // first-press latch reacts to the press pulse currently visible
        if (m_press != 0 && (!m_fv || a)) begin
            m_fv = 1;
            for (int i = 3; i >= 0; i--) if (m_press[i]) m_fk = 2'(i);
        end else if (a) begin
            m_fv = 0;
            m_fk = 0;
        end
        np = 0; nr = 0; ne = 0;
        if (e) begin
            m_idle = 0;
            if (d == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else if (d == 8'h00 || d == 8'hFF) begin
                ne = 1; m_ext = 0; m_brk = 0;
            end else begin
                key = -1;
                if (m_ext) begin
                    if (d == 8'h5A) key = 1;
                end else begin
                    foreach (codes[i]) if (codes[i] == d) key = i;
                end
                if (key >= 0) begin
                    if (!m_brk && !m_held[key]) begin
                        m_held[key] = 1; np[key] = 1'b1;
                    end else if (m_brk && m_held[key]) begin
                        m_held[key] = 0; nr[key] = 1'b1;
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == T) begin
                ne = 1; m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
        m_press = np; m_rel = nr; m_err = ne;
    endtask

    // One clock cycle of stimulus, then compare against the model.
    task automatic step(input logic [7:0] d, input bit e, input bit a, input bit r);
        received_data    = d;
        received_data_en = e;
        arm              = a;
        reset            = r;
        @(posedge CLOCK_50);
        #1;
        model_step(d, e, a, r);
        check("model", dut_vec, model_vec());
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        string       name;
        logic [7:0]  d;
        bit          e;
        bit          a;
        bit          r;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [7:0] d, input bit e,
                                input bit a, input bit r, input logic [15:0] exp);
        vec_t v;
        v.name = n; v.d = d; v.e = e; v.a = a; v.r = r; v.exp = exp;
        return v;
    endfunction

    initial begin
        int density;
        logic [7:0] pool [10] = '{8'h29, 8'h5A, 8'h16, 8'h1E, 8'hE0, 8'hF0,
                                  8'h00, 8'hFF, 8'h29, 8'hF0};
        logic [7:0] d;

        received_data = 8'h00; received_data_en = 0; arm = 0; reset = 0;

        // reset and typematic / break of space
        vecs.push_back(mk("reset",        8'h00, 0, 0, 1, pk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("space_make",   8'h29, 1, 0, 0, pk(4'b0001, 4'b0001, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("space_rep1",   8'h29, 1, 0, 0, pk(4'b0001, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("space_rep2",   8'h29, 1, 0, 0, pk(4'b0001, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("space_f0",     8'hF0, 1, 0, 0, pk(4'b0001, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("space_brk",    8'h29, 1, 0, 0, pk(4'b0000, 4'b0000, 4'b0001, 0, 1, 0)));
        vecs.push_back(mk("idle0",        8'h00, 0, 0, 0, pk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0)));
        // keypad enter make/break, unmapped extended code
        vecs.push_back(mk("kp_e0",        8'hE0, 1, 0, 0, pk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("kp_make",      8'h5A, 1, 0, 0, pk(4'b0010, 4'b0010, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("kp_e0b",       8'hE0, 1, 0, 0, pk(4'b0010, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("kp_f0",        8'hF0, 1, 0, 0, pk(4'b0010, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("kp_brk",       8'h5A, 1, 0, 0, pk(4'b0000, 4'b0000, 4'b0010, 0, 1, 0)));
        vecs.push_back(mk("ext16_e0",     8'hE0, 1, 0, 0, pk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("ext16_code",   8'h16, 1, 0, 0, pk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0)));
        vecs.push_back(mk("idle1",        8'h00, 0, 0, 0, pk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0)));
        // first-press latch
        vecs.push_back(mk("arm",          8'h00, 0, 1, 0, pk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("two_make",     8'h1E, 1, 0, 0, pk(4'b1000, 4'b1000, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("one_make",     8'h16, 1, 0, 0, pk(4'b1100, 4'b0100, 4'b0000, 3, 1, 0)));
        vecs.push_back(mk("first_hold",   8'h00, 0, 0, 0, pk(4'b1100, 4'b0000, 4'b0000, 3, 1, 0)));
        vecs.push_back(mk("one_f0",       8'hF0, 1, 0, 0, pk(4'b1100, 4'b0000, 4'b0000, 3, 1, 0)));
        vecs.push_back(mk("one_brk",      8'h16, 1, 0, 0, pk(4'b1000, 4'b0000, 4'b0100, 3, 1, 0)));
        vecs.push_back(mk("arm_with_one", 8'h16, 1, 1, 0, pk(4'b1100, 4'b0100, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("first_one",    8'h00, 0, 0, 0, pk(4'b1100, 4'b0000, 4'b0000, 2, 1, 0)));
        // error byte mid-sequence
        vecs.push_back(mk("err_e0",       8'hE0, 1, 0, 0, pk(4'b1100, 4'b0000, 4'b0000, 2, 1, 0)));
        vecs.push_back(mk("err_ff",       8'hFF, 1, 0, 0, pk(4'b1100, 4'b0000, 4'b0000, 2, 1, 1)));
        vecs.push_back(mk("after_err",    8'h29, 1, 0, 0, pk(4'b1101, 4'b0001, 4'b0000, 2, 1, 0)));
        vecs.push_back(mk("idle2",        8'h00, 0, 0, 0, pk(4'b1101, 4'b0000, 4'b0000, 2, 1, 0)));
        // reset in EXT_BRK with all keys held, strobe in the reset cycle
        vecs.push_back(mk("enter_make",   8'h5A, 1, 0, 0, pk(4'b1111, 4'b0010, 4'b0000, 2, 1, 0)));
        vecs.push_back(mk("xb_e0",        8'hE0, 1, 0, 0, pk(4'b1111, 4'b0000, 4'b0000, 2, 1, 0)));
        vecs.push_back(mk("xb_f0",        8'hF0, 1, 0, 0, pk(4'b1111, 4'b0000, 4'b0000, 2, 1, 0)));
        vecs.push_back(mk("reset_strobe", 8'h29, 1, 0, 1, pk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("post_rst_5a",  8'h5A, 1, 0, 0, pk(4'b0010, 4'b0010, 4'b0000, 0, 0, 0)));
        vecs.push_back(mk("post_rst_fk",  8'h00, 0, 0, 0, pk(4'b0010, 4'b0000, 4'b0000, 1, 1, 0)));

        foreach (vecs[i]) begin
            step(vecs[i].d, vecs[i].e, vecs[i].a, vecs[i].r);
            check(vecs[i].name, dut_vec, vecs[i].exp);
        end

        // Prefix timeout: F0 then T quiet cycles, error only on the last one.
        step(8'hF0, 1, 0, 0);
        for (int i = 1; i <= T; i++) begin
            step(8'h00, 0, 0, 0);
            check("timeout_err", {15'd0, proto_error}, {15'd0, (i == T)});
        end
        step(8'h29, 1, 0, 0);
        check("timeout_make", dut_vec, pk(4'b0011, 4'b0001, 4'b0000, 1, 1, 0));

        // One cycle short of the timeout, the break still completes.
        step(8'hF0, 1, 0, 0);
        for (int i = 1; i < T; i++) step(8'h00, 0, 0, 0);
        step(8'h29, 1, 0, 0);
        check("late_break", dut_vec, pk(4'b0010, 4'b0000, 4'b0001, 1, 1, 0));

        // Randomized traffic with varying byte density to reach timeouts.
        density = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       density = 60;
                    1:       density = 10;
                    default: density = 3;
                endcase
            end
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = pool[$urandom_range(0, 9)];
            step(d,
                 $urandom_range(0, 99) < density,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
